// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the round-robin priority arbiter.
package arb_pkg;

    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit priority encoder: index of the lowest set bit and a valid flag.
module prio_enc_lsb #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
                o_vld = 1'b1;
            end else begin
                o_idx = o_idx;
                o_vld = o_vld;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter: registered one-hot grant, held until the owner finishes or drops its request.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int IDX_W = ARB_IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    input  logic [N-1:0]     i_req,
    input  logic             i_done,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    arb_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt, w_ptr_eff;
    logic [N-1:0]     r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_nxt;
    logic             r_gnt_vld, w_gnt_vld_nxt;

    logic             w_rel;
    logic [N-1:0]     w_mask, w_masked, w_win_onehot;
    logic [IDX_W-1:0] w_m_idx, w_u_idx, w_win_idx;
    logic             w_m_vld, w_u_vld;

    // On release the pointer moves past the owner in the same cycle, so the search uses it already.
    always_comb begin
        w_rel = i_done | ~i_req[r_gnt_idx];
        if ((r_state == GRANT) && w_rel) begin
            w_ptr_eff = r_gnt_idx + IDX_W'(1'b1);
        end else begin
            w_ptr_eff = r_ptr;
        end
    end

    assign w_mask   = {N{1'b1}} << w_ptr_eff;
    assign w_masked = i_req & w_mask;

    prio_enc_lsb #(.N(N), .IDX_W(IDX_W)) u_enc_masked (
        .i_vec (w_masked),
        .o_idx (w_m_idx),
        .o_vld (w_m_vld)
    );

    prio_enc_lsb #(.N(N), .IDX_W(IDX_W)) u_enc_unmasked (
        .i_vec (i_req),
        .o_idx (w_u_idx),
        .o_vld (w_u_vld)
    );

    assign w_win_idx    = w_m_vld ? w_m_idx : w_u_idx;
    assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win_idx;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_gnt_vld_nxt = r_gnt_vld;
        case (r_state)
            IDLE: begin
                if (i_ena && w_u_vld) begin
                    w_state_nxt   = GRANT;
                    w_gnt_nxt     = w_win_onehot;
                    w_gnt_idx_nxt = w_win_idx;
                    w_gnt_vld_nxt = 1'b1;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            GRANT: begin
                if (w_rel) begin
                    w_ptr_nxt = w_ptr_eff;
                    if (i_ena && w_u_vld) begin
                        w_gnt_nxt     = w_win_onehot;
                        w_gnt_idx_nxt = w_win_idx;
                        w_gnt_vld_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = IDLE;
                        w_gnt_nxt     = '0;
                        w_gnt_vld_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = GRANT;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_gnt_nxt     = '0;
                w_gnt_vld_nxt = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_idx = r_gnt_idx;
    assign o_gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a circular-search reference model.
module tb_rr_priority_arbiter;
    import arb_pkg::*;

    localparam int N = ARB_N;
    localparam int W = ARB_IDX_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         gnt_vld;

    int checks = 0;
    int errors = 0;

    // Reference model: busy flag, current owner, round-robin start point.
    bit m_busy;
    int m_idx;
    int m_ptr;

    rr_priority_arbiter dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ena     (ena),
        .i_req     (req),
        .i_done    (done),
        .o_gnt     (gnt),
        .o_gnt_idx (gnt_idx),
        .o_gnt_vld (gnt_vld)
    );

    always #5 clk = ~clk;

    // First requester found walking circularly upward from p.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (m_busy) eg[m_idx] = 1'b1;
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".idx"}, 32'(gnt_idx), m_idx);
        check({tag, ".vld"}, 32'(gnt_vld), 32'(m_busy));
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
    endtask

    // One clock: predict from current inputs, advance, then compare away from the edge.
    task automatic step(input string tag);
        bit nb;
        int ni, np;
        nb = m_busy; ni = m_idx; np = m_ptr;
        if (rst) begin
            nb = 1'b0; ni = 0; np = 0;
        end else if (!m_busy) begin
            if (ena && req != '0) begin
                nb = 1'b1;
                ni = pick(req, m_ptr);
            end
        end else if (done || !req[m_idx]) begin
            np = (m_idx + 1) % N;
            if (ena && req != '0) ni = pick(req, np);
            else nb = 1'b0;
        end
        @(posedge clk);
        #1;
        m_busy = nb; m_idx = ni; m_ptr = np;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = 1'b0; ena = 1'b1;
        step("rst");
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1; ena = 1'b1; req = 8'hFF; done = 1'b0;
        #1;
        check_model("reset0");
        for (int i = 0; i < 3; i++) step("reset_hold");
        check("reset_vld", 32'(gnt_vld), 32'd0);
        rst = 1'b0;

        // Single request, hold, release by done.
        req = 8'h20;
        step("single");
        check("single_gnt", 32'(gnt), 32'h20);
        check("single_idx", 32'(gnt_idx), 32'd5);
        step("single_hold");
        step("single_hold");
        done = 1'b1; req = '0;
        step("single_rel");
        check("single_idle", 32'(gnt_vld), 32'd0);
        check("single_idx_kept", 32'(gnt_idx), 32'd5);
        done = 1'b0;

        // Full round robin with back-to-back handoffs.
        do_reset();
        req = 8'hFF; done = 1'b1;
        for (int k = 0; k <= N; k++) begin
            step("rr");
            check("rr_idx", 32'(gnt_idx), 32'(k % N));
            check("rr_vld", 32'(gnt_vld), 32'd1);
        end
        done = 1'b0;

        // Two requesters wrapping around.
        do_reset();
        req = 8'h81;
        step("two");
        check("two_0", 32'(gnt_idx), 32'd0);
        done = 1'b1;
        step("two");
        check("two_7", 32'(gnt_idx), 32'd7);
        step("two");
        check("two_wrap", 32'(gnt_idx), 32'd0);
        done = 1'b0;

        // Release by dropping the request.
        do_reset();
        req = 8'h48;
        step("drop");
        check("drop_3", 32'(gnt_idx), 32'd3);
        req = 8'h40;
        step("drop");
        check("drop_6", 32'(gnt_idx), 32'd6);
        check("drop_vld", 32'(gnt_vld), 32'd1);

        // Enable behaviour.
        do_reset();
        ena = 1'b0; req = 8'h0F;
        step("ena_off");
        step("ena_off");
        check("ena_off_vld", 32'(gnt_vld), 32'd0);
        ena = 1'b1;
        step("ena_on");
        check("ena_on_idx", 32'(gnt_idx), 32'd0);
        ena = 1'b0;
        step("ena_mid");
        check("ena_mid_hold", 32'(gnt), 32'h01);
        done = 1'b1;
        step("ena_rel");
        check("ena_rel_idle", 32'(gnt_vld), 32'd0);
        done = 1'b0; ena = 1'b1;
        step("regrant");
        check("regrant_idx", 32'(gnt_idx), 32'd1);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_vld", 32'(gnt_vld), 32'd0);
        check("async_idx", 32'(gnt_idx), 32'd0);
        step("async_hold");
        rst = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req  = N'($urandom) & N'($urandom);
            done = ($urandom_range(0, 3) == 0);
            ena  = ($urandom_range(0, 7) != 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
